// File: rtl/lut_cfg_pkg.sv
// Shared definitions for LUTRAM configuration loading: FSM encoding and sizing helpers.
// Also used by the fabric config top level to size the config stream.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r = 0;
    int x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int total_bits(input int k, input int num_luts);
    return num_luts << k;
  endfunction

  function automatic int num_words(input int k, input int num_luts, input int word_w);
    return (total_bits(k, num_luts) + word_w - 1) / word_w;
  endfunction

  // A power-of-two total gets a spare bit so the final-index compare never aliases to zero.
  function automatic int idx_width(input int total);
    return ((total & (total - 1)) == 0) ? clog2(total) + 1 : clog2(total);
  endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Config word shift register: serialises one word bit 0 first and tracks bits remaining.
// Latency: load/shift take effect at the next rising edge; bit0 is the bit currently presented.
// Backpressure: none; the caller decides when to load or shift.
module lut_cfg_shifter import lut_cfg_pkg::*; #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              bit0,
  output logic              last_bit
);

  localparam int CW = clog2(WORD_W) + 1;

  logic [WORD_W-1:0] sr;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= CW'(WORD_W);
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign bit0     = sr[0];
  assign last_bit = (cnt == CW'(1));

endmodule

// File: rtl/lut_config_loader.sv
// Serialises a config word stream into per-bit LUTRAM writes (shared addr/data, one-hot enable).
// Latency: word accepted at edge N drives its bit 0 in cycle N+1, then one bit per cycle.
// Backpressure: cfg_ready only in WAIT or on a word's last bit; a missing word stalls in WAIT.
module lut_config_loader import lut_cfg_pkg::*; #(
  parameter int K        = 6,
  parameter int NUM_LUTS = 8,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [K-1:0]        wr_addr,
  output logic                wr_data,
  output logic [NUM_LUTS-1:0] wr_en,
  output logic                busy,
  output logic                cfg_done
);

  localparam int TOTAL = total_bits(K, NUM_LUTS);
  localparam int IW    = idx_width(TOTAL);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

  state_t              state, state_nxt;
  logic [IW-1:0]       bit_idx, bit_idx_nxt;
  logic [NUM_LUTS-1:0] wr_en_nxt;
  logic                sr_load, sr_shift, sr_bit0, sr_last, final_bit;

  lut_cfg_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load),
    .load_data (cfg_data),
    .shift     (sr_shift),
    .bit0      (sr_bit0),
    .last_bit  (sr_last)
  );

  assign final_bit = (bit_idx == LAST_IDX);
  // The final word never re-opens the stream, even when it fills exactly.
  assign cfg_ready = (state == ST_WAIT) || (state == ST_SHIFT && sr_last && !final_bit);

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    wr_en_nxt   = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_WAIT;
          bit_idx_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (cfg_valid) begin
          sr_load   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (final_bit) begin
          state_nxt = ST_DONE;
        end else begin
          bit_idx_nxt = bit_idx + 1'b1;
          if (!sr_last)
            sr_shift = 1'b1;
          else if (cfg_valid)
            sr_load = 1'b1;
          else
            state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Enable is precomputed for the next cycle so the LUTRAM sees a glitch-free flop.
    if (state_nxt == ST_SHIFT)
      wr_en_nxt = NUM_LUTS'(1) << (bit_idx_nxt >> K);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      wr_en   <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      wr_en   <= wr_en_nxt;
    end
  end

  assign wr_addr  = bit_idx[K-1:0];
  assign wr_data  = sr_bit0;
  assign busy     = (state == ST_WAIT) || (state == ST_SHIFT);
  assign cfg_done = (state == ST_DONE);

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: a K=6/2-LUT instance for the main passes and a K=4/3-LUT
// instance for final-word truncation; written LUTRAM contents are rebuilt from the write bus.
module tb_lut_config_loader;

  localparam int K = 6, NL = 2, W = 32, TOT = 128, NW = 4, LUT_BITS = 64;
  localparam int KB = 4, NLB = 3, TOTB = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, cfg_valid, cfg_ready, wr_data, busy, cfg_done;
  logic [W-1:0]  cfg_data;
  logic [K-1:0]  wr_addr;
  logic [NL-1:0] wr_en;
  logic           start_b, valid_b, ready_b, wdat_b, busy_b, done_b;
  logic [W-1:0]   data_b;
  logic [KB-1:0]  addr_b;
  logic [NLB-1:0] en_b;

  lut_config_loader #(.K(K), .NUM_LUTS(NL), .WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .cfg_done(cfg_done));

  lut_config_loader #(.K(KB), .NUM_LUTS(NLB), .WORD_W(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_data(data_b), .cfg_valid(valid_b),
    .cfg_ready(ready_b), .wr_addr(addr_b), .wr_data(wdat_b), .wr_en(en_b),
    .busy(busy_b), .cfg_done(done_b));

  int checks = 0, errors = 0;
  logic [31:0]   words [NW];
  logic [63:0]   mask_a [NL];
  logic [15:0]   mask_b [NLB];
  logic [NL-1:0] log_en[$];
  logic [K-1:0]  log_addr[$];
  logic          log_dat[$];
  int            log_cyc[$];
  int            cyc = 0, done_cyc = -1, nwr_b = 0;
  logic          done_q = 1'b0;

  // LUTRAM model: every enabled cycle is a write, as lut_custom would see it.
  always @(negedge clk) begin
    cyc++;
    if (wr_en != '0) begin
      log_en.push_back(wr_en);
      log_addr.push_back(wr_addr);
      log_dat.push_back(wr_data);
      log_cyc.push_back(cyc);
      for (int i = 0; i < NL; i++) if (wr_en[i]) mask_a[i][wr_addr] = wr_data;
    end
    if (cfg_done && !done_q) done_cyc = cyc;
    done_q = cfg_done;
    if (en_b != '0) begin
      nwr_b++;
      for (int i = 0; i < NLB; i++) if (en_b[i]) mask_b[i][addr_b] = wdat_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    int t = 0;
    bit acc = 1'b0;
    do begin
      @(negedge clk); acc = cfg_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 400);
    chk(tag, acc, 1);
  endtask

  // g>0: hold off until the loader asks for data, then leave it waiting g more cycles.
  task automatic send_word(input logic [31:0] w, input int g);
    if (g > 0) begin
      cfg_valid = 1'b0;
      wait_accept("ready_timeout");
      repeat (g) begin @(posedge clk); #1; end
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    wait_accept("accept_timeout");
    cfg_valid = 1'b0;
    cfg_data  = $urandom;
  endtask

  // stall_mode < 0 draws a random gap (0..3) per word.
  task automatic run_pass(input string tag, input int stall_mode, input bit mid_start);
    int exp_span, g, t, last;
    logic [31:0] w;
    logic [NL-1:0] en;
    log_en.delete(); log_addr.delete(); log_dat.delete(); log_cyc.delete();
    done_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done_clr"}, cfg_done, 0);
    exp_span = TOT - 1;
    for (int i = 0; i < NW; i++) begin
      g = (stall_mode < 0) ? int'($urandom_range(3, 0)) : stall_mode;
      if (i > 0 && g > 0) exp_span += g + 1;
      send_word(words[i], g);
      if (mid_start && i == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (cfg_done !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    @(negedge clk); #1;
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_nwrites"}, log_en.size(), TOT);
    if (log_en.size() == TOT) begin
      for (int n = 0; n < TOT; n++) begin
        w  = words[n / 32];
        en = NL'(1) << (n / LUT_BITS);
        chk("wr_seq", {log_en[n], log_addr[n], log_dat[n]}, {en, K'(n % LUT_BITS), w[n % 32]});
      end
      last = log_cyc[TOT-1];
      chk({tag, "_span"}, last - log_cyc[0], exp_span);
      chk({tag, "_done_cycle"}, done_cyc, last + 1);
    end
    chk({tag, "_lut0"}, mask_a[0], {words[1], words[0]});
    chk({tag, "_lut1"}, mask_a[1], {words[3], words[2]});
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [31:0] w);
    int t = 0;
    bit acc = 1'b0;
    valid_b = 1'b1;
    data_b  = w;
    do begin
      @(negedge clk); acc = ready_b;
      @(posedge clk); #1; t++;
    end while (!acc && t < 400);
    chk("t4_accept", acc, 1);
    valid_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n0;
    bit rdy_seen;
    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {cfg_ready, busy, cfg_done, wr_en, wr_addr, wr_data}, 0);
    chk("rst_outs_b", {ready_b, busy_b, done_b, en_b, addr_b, wdat_b}, 0);

    // Idle after reset: valid is offered but nothing may be accepted without start.
    @(negedge clk) rst_n = 1'b1;
    cfg_valid = 1'b1; cfg_data = 32'hCAFEF00D;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("idle_outs", {cfg_ready, busy, cfg_done, wr_en, wr_addr, wr_data}, 0);
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;

    words = '{32'hDEADBEEF, 32'h01234567, 32'hFFFF0000, 32'h0000FFFF};
    run_pass("t2", 0, 1'b0);
    run_pass("t3", 3, 1'b0);

    // Truncated final word on the 3-LUT instance.
    nwr_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    send_b(32'hAAAA5555);
    send_b(32'h9999C3C3);
    valid_b = 1'b1; data_b = 32'h12345678;
    rdy_seen = 1'b0;
    t = 0;
    while (done_b !== 1'b1 && t < 200) begin
      @(negedge clk); if (ready_b) rdy_seen = 1'b1;
      @(posedge clk); #1; t++;
    end
    @(negedge clk); #1;
    valid_b = 1'b0;
    chk("t4_done", done_b, 1);
    chk("t4_no_extra", rdy_seen, 0);
    chk("t4_nwrites", nwr_b, TOTB);
    chk("t4_lut0", mask_b[0], 16'h5555);
    chk("t4_lut1", mask_b[1], 16'hAAAA);
    chk("t4_lut2", mask_b[2], 16'hC3C3);
    @(posedge clk); #1;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NW; i++) words[i] = $urandom;
      run_pass("rand", -1, 1'b0);
    end

    // Start mid-pass is ignored; offered data in DONE is never taken.
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    run_pass("t5", -1, 1'b1);
    n0 = log_en.size();
    cfg_valid = 1'b1; cfg_data = 32'h5A5A5A5A;
    rdy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (cfg_ready) rdy_seen = 1'b1;
    end
    cfg_valid = 1'b0;
    chk("t5_done_ready", rdy_seen, 0);
    chk("t5_done_nowrite", log_en.size(), n0);
    chk("t5_done_hold", cfg_done, 1);
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) words[i] = 32'h0;
    run_pass("t5zero", 0, 1'b0);

    // Reset while bit 40 is on the bus.
    words = '{32'hDEADBEEF, 32'h01234567, 32'hFFFF0000, 32'h0000FFFF};
    log_en.delete(); log_addr.delete(); log_dat.delete(); log_cyc.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(words[0], 0);
    send_word(words[1], 0);
    t = 0;
    while (log_en.size() < 41 && t < 200) begin @(negedge clk); #1; t++; end
    chk("t6_reached_bit40", log_en.size(), 41);
    rst_n = 1'b0;
    #1;
    chk("t6_async_wr_en", wr_en, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_done", cfg_done, 0);
    chk("t6_async_ready", cfg_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("t6_idle_after", {busy, wr_en, cfg_done}, 0);
    @(posedge clk); #1;
    run_pass("t6", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
